// File: rtl/corevx_icache_dm_if.sv
// Fetch-side cache bus plus the single-outstanding backing read port.
// slave = cache view, master = fetch stage / memory view.
interface corevx_icache_dm_if;
  logic [3:0]  c_cmd;
  logic [31:0] c_address;
  logic [3:0]  c_response;
  logic [31:0] c_load_data;
  logic        c_reset_done;
  logic        m_req;
  logic [31:0] m_addr;
  logic        m_ack;
  logic [31:0] m_rdata;
  logic        m_err;

  modport slave (
    input  c_cmd, c_address,
    output c_response, c_load_data, c_reset_done,
    output m_req, m_addr,
    input  m_ack, m_rdata, m_err
  );

  modport master (
    output c_cmd, c_address,
    input  c_response, c_load_data, c_reset_done,
    input  m_req, m_addr,
    output m_ack, m_rdata, m_err
  );
endinterface

// File: rtl/corevx_cache.svh
// Command and response encodings shared by the fetch-side cache interface.
`ifndef COREVX_CACHE_SVH
`define COREVX_CACHE_SVH

`define CACHE_CMD_NONE              4'd0
`define CACHE_CMD_LOAD              4'd1
`define CACHE_CMD_STORE             4'd2
`define CACHE_CMD_EXECUTE           4'd3
`define CACHE_CMD_FLUSH_ALL         4'd4

`define CACHE_RESPONSE_IDLE         4'd0
`define CACHE_RESPONSE_WAIT         4'd1
`define CACHE_RESPONSE_DONE         4'd2
`define CACHE_RESPONSE_MISSALIGNED  4'd3
`define CACHE_RESPONSE_ACCESSFAULT  4'd4
`define CACHE_RESPONSE_PAGEFAULT    4'd5

`endif

// File: rtl/corevx_icache_dm.sv
// Direct-mapped read-only instruction cache with word-by-word line refill.
// Optional hit/miss counters are enabled by defining COREVX_ICACHE_PERF_EN.
`include "corevx_cache.svh"

module corevx_icache_dm #(
  parameter int LANES_W  = 4,
  parameter int OFFSET_W = 2
) (
  input  logic clk,
  input  logic rst_n,
  corevx_icache_dm_if.slave bus
`ifdef COREVX_ICACHE_PERF_EN
  ,
  output logic [31:0] perf_hits,
  output logic [31:0] perf_misses
`endif
);
  localparam int TAG_W = 30 - LANES_W - OFFSET_W;
  localparam int LINES = 1 << LANES_W;
  localparam int WORDS = 1 << OFFSET_W;

  typedef enum logic [1:0] {S_INV, S_ACTIVE, S_REFILL, S_FLUSH} state_t;

  state_t               r_state;
  logic [LINES-1:0]     r_valid;
  logic [TAG_W-1:0]     r_tags [0:LINES-1];
  logic [31:0]          r_data [0:LINES*WORDS-1];
  logic [LANES_W-1:0]   r_sweep;
  logic [OFFSET_W-1:0]  r_word;
  logic [TAG_W-1:0]     r_tag_q;
  logic [LANES_W-1:0]   r_idx_q;
  logic [OFFSET_W-1:0]  r_off_q;
  logic [31:0]          r_crit;

  logic [TAG_W-1:0]     w_tag;
  logic [LANES_W-1:0]   w_idx;
  logic [OFFSET_W-1:0]  w_off;
  logic [OFFSET_W-1:0]  w_word_inc;
  logic                 w_hit;
  logic                 w_fill;

  assign w_tag      = bus.c_address[31 -: TAG_W];
  assign w_idx      = bus.c_address[2+OFFSET_W +: LANES_W];
  assign w_off      = bus.c_address[2 +: OFFSET_W];
  assign w_word_inc = r_word + 1'b1;
  assign w_hit      = r_valid[w_idx] && (r_tags[w_idx] == w_tag);
  // A good refill beat: only honoured while our own request is outstanding.
  assign w_fill     = (r_state == S_REFILL) && bus.m_req && bus.m_ack && !bus.m_err;

  // Line storage: data words and tags are written as refill beats land.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_data[{r_idx_q, r_word}] <= bus.m_rdata;
      if (&r_word) r_tags[r_idx_q] <= r_tag_q;
    end
  end

  // Control FSM: invalidate sweep, command accept, refill and flush.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state          <= S_INV;
      r_sweep          <= '0;
      r_word           <= '0;
      bus.c_response   <= `CACHE_RESPONSE_IDLE;
      bus.c_reset_done <= 1'b0;
      bus.c_load_data  <= '0;
      bus.m_req        <= 1'b0;
      bus.m_addr       <= '0;
    end else begin
      case (r_state)
        S_INV: begin
          r_valid[r_sweep] <= 1'b0;
          r_sweep          <= r_sweep + 1'b1;
          if (&r_sweep) begin
            bus.c_reset_done <= 1'b1;
            r_state          <= S_ACTIVE;
          end
        end
        S_ACTIVE: begin
          case (bus.c_cmd)
            `CACHE_CMD_NONE: bus.c_response <= `CACHE_RESPONSE_IDLE;
            `CACHE_CMD_EXECUTE: begin
              if (bus.c_address[1:0] != 2'b00) begin
                bus.c_response <= `CACHE_RESPONSE_MISSALIGNED;
              end else if (w_hit) begin
                bus.c_response  <= `CACHE_RESPONSE_DONE;
                bus.c_load_data <= r_data[{w_idx, w_off}];
              end else begin
                // Drop the line before refilling so a failed refill leaves it invalid.
                bus.c_response <= `CACHE_RESPONSE_WAIT;
                r_valid[w_idx] <= 1'b0;
                r_tag_q        <= w_tag;
                r_idx_q        <= w_idx;
                r_off_q        <= w_off;
                r_word         <= '0;
                r_state        <= S_REFILL;
              end
            end
            `CACHE_CMD_FLUSH_ALL: begin
              bus.c_response <= `CACHE_RESPONSE_WAIT;
              r_sweep        <= '0;
              r_state        <= S_FLUSH;
            end
            default: bus.c_response <= `CACHE_RESPONSE_ACCESSFAULT;
          endcase
        end
        S_REFILL: begin
          if (!bus.m_req) begin
            bus.m_req  <= 1'b1;
            bus.m_addr <= {r_tag_q, r_idx_q, r_word, 2'b00};
          end else if (bus.m_ack) begin
            if (bus.m_err) begin
              bus.m_req      <= 1'b0;
              bus.c_response <= `CACHE_RESPONSE_ACCESSFAULT;
              r_state        <= S_ACTIVE;
            end else begin
              // Keep the requested word aside so the final beat need not re-read the array.
              if (r_word == r_off_q) r_crit <= bus.m_rdata;
              if (&r_word) begin
                bus.m_req        <= 1'b0;
                r_valid[r_idx_q] <= 1'b1;
                bus.c_response   <= `CACHE_RESPONSE_DONE;
                bus.c_load_data  <= (r_word == r_off_q) ? bus.m_rdata : r_crit;
                r_state          <= S_ACTIVE;
              end else begin
                r_word     <= w_word_inc;
                bus.m_addr <= {r_tag_q, r_idx_q, w_word_inc, 2'b00};
              end
            end
          end
        end
        S_FLUSH: begin
          r_valid[r_sweep] <= 1'b0;
          r_sweep          <= r_sweep + 1'b1;
          if (&r_sweep) begin
            bus.c_response <= `CACHE_RESPONSE_DONE;
            r_state        <= S_ACTIVE;
          end
        end
        default: r_state <= S_INV;
      endcase
    end
  end

`ifdef COREVX_ICACHE_PERF_EN
  logic w_acc_exec;
  logic w_flush_done;
  assign w_acc_exec   = (r_state == S_ACTIVE) && (bus.c_cmd == `CACHE_CMD_EXECUTE) &&
                        (bus.c_address[1:0] == 2'b00);
  assign w_flush_done = (r_state == S_FLUSH) && (&r_sweep);

  // Saturating hit/miss counters, cleared when a flush completes.
  always_ff @(posedge clk) begin
    if (!rst_n || w_flush_done) begin
      perf_hits   <= '0;
      perf_misses <= '0;
    end else begin
      if (w_acc_exec && w_hit && perf_hits != 32'hFFFF_FFFF)
        perf_hits <= perf_hits + 1'b1;
      if (w_acc_exec && !w_hit && perf_misses != 32'hFFFF_FFFF)
        perf_misses <= perf_misses + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_corevx_icache_dm.sv
// Directed self-checking bench for corevx_icache_dm with a simple backing memory model.
module tb_corevx_icache_dm;
  localparam logic [3:0] CMD_NONE = 4'd0, CMD_EXECUTE = 4'd3, CMD_FLUSH = 4'd4, CMD_BAD = 4'd9;
  localparam logic [3:0] RSP_IDLE = 4'd0, RSP_WAIT = 4'd1, RSP_DONE = 4'd2;
  localparam logic [3:0] RSP_MIS = 4'd3, RSP_AF = 4'd4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_checks = 0;
  int n_errors = 0;

  corevx_icache_dm_if bus ();
`ifdef COREVX_ICACHE_PERF_EN
  logic [31:0] perf_hits, perf_misses;
`endif

  corevx_icache_dm dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
`ifdef COREVX_ICACHE_PERF_EN
    ,
    .perf_hits(perf_hits),
    .perf_misses(perf_misses)
`endif
  );

  initial forever #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  // Memory model controls (written by the bench, read by the model).
  int          mem_lat  = 2;
  logic [31:0] err_addr = 32'hFFFF_FFFF;
  int          inj_req  = 0;
  // Model state (written by the model only).
  int          inj_done = 0;
  logic [31:0] log_q[$];

  initial begin
    int cnt;
    cnt = 0;
    bus.m_ack = 1'b0;
    bus.m_rdata = '0;
    bus.m_err = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.m_ack = 1'b0;
      bus.m_err = 1'b0;
      if (inj_req != inj_done) begin
        inj_done = inj_req;
        bus.m_ack = 1'b1;
        bus.m_rdata = 32'hDEAD_BEEF;
      end else if (bus.m_req) begin
        cnt++;
        if (cnt >= mem_lat) begin
          cnt = 0;
          bus.m_ack = 1'b1;
          bus.m_rdata = mem_word(bus.m_addr);
          bus.m_err = (bus.m_addr == err_addr);
          log_q.push_back(bus.m_addr);
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    int k;
    int bad;
    rst_n = 1'b0;
    bus.c_cmd = CMD_NONE;
    bus.c_address = '0;
    repeat (3) tick();
    n_checks++; if (bus.c_response !== RSP_IDLE) begin n_errors++; $display("FAIL rst_resp: got %0d want %0d", bus.c_response, RSP_IDLE); end
    n_checks++; if (bus.c_reset_done !== 1'b0) begin n_errors++; $display("FAIL rst_done: got %b want 0", bus.c_reset_done); end
    n_checks++; if (bus.c_load_data !== 32'h0) begin n_errors++; $display("FAIL rst_data: got %h want 0", bus.c_load_data); end
    n_checks++; if (bus.m_req !== 1'b0) begin n_errors++; $display("FAIL rst_mreq: got %b want 0", bus.m_req); end
    n_checks++; if (bus.m_addr !== 32'h0) begin n_errors++; $display("FAIL rst_maddr: got %h want 0", bus.m_addr); end
    // Commands presented during the sweep must be ignored.
    bus.c_cmd = CMD_EXECUTE;
    bus.c_address = 32'h2000;
    rst_n = 1'b1;
    k = 0;
    bad = 0;
    while (k < 40 && bus.c_reset_done !== 1'b1) begin
      tick();
      k++;
      if (bus.c_response !== RSP_IDLE || bus.m_req !== 1'b0) bad++;
    end
    bus.c_cmd = CMD_NONE;
    n_checks++; if (k !== 16) begin n_errors++; $display("FAIL sweep_len: got %0d cycles want 16", k); end
    n_checks++; if (bad !== 0) begin n_errors++; $display("FAIL sweep_quiet: %0d non-idle cycles want 0", bad); end
    tick();
    n_checks++; if (bus.c_response !== RSP_IDLE) begin n_errors++; $display("FAIL post_sweep_idle: got %0d want %0d", bus.c_response, RSP_IDLE); end
    $display("txn reset: reset_done after %0d cycles", k);
  endtask

  task automatic test_cold_miss();
    int k;
    int base;
    logic [31:0] a;
    base = log_q.size();
    mem_lat = 2;
    bus.c_cmd = CMD_EXECUTE;
    bus.c_address = 32'h2000;
    tick();
    n_checks++; if (bus.c_response !== RSP_WAIT) begin n_errors++; $display("FAIL miss_wait: got %0d want %0d", bus.c_response, RSP_WAIT); end
    tick();
    n_checks++; if (bus.m_req !== 1'b1 || bus.m_addr !== 32'h2000) begin n_errors++; $display("FAIL miss_req: m_req=%b m_addr=%h want 1/00002000", bus.m_req, bus.m_addr); end
    k = 2;
    while (k < 60 && bus.c_response === RSP_WAIT) begin tick(); k++; end
    n_checks++; if (k !== 10) begin n_errors++; $display("FAIL miss_latency: got %0d want 10", k); end
    n_checks++; if (bus.c_response !== RSP_DONE) begin n_errors++; $display("FAIL miss_done: got %0d want %0d", bus.c_response, RSP_DONE); end
    n_checks++; if (bus.c_load_data !== mem_word(32'h2000)) begin n_errors++; $display("FAIL miss_data: got %h want %h", bus.c_load_data, mem_word(32'h2000)); end
    n_checks++; if (log_q.size() - base !== 4) begin n_errors++; $display("FAIL miss_beats: got %0d want 4", log_q.size() - base); end
    for (int i = 0; i < 4; i++) begin
      a = (base + i < log_q.size()) ? log_q[base + i] : 32'hXXXX_XXXX;
      n_checks++; if (a !== 32'h2000 + 32'(4 * i)) begin n_errors++; $display("FAIL miss_addr%0d: got %h want %h", i, a, 32'h2000 + 32'(4 * i)); end
    end
    $display("txn EXECUTE 0x2000 (cold): resp=%0d data=%h latency=%0d", bus.c_response, bus.c_load_data, k);
    // Same line, different word: single-cycle hit with no backing traffic.
    base = log_q.size();
    bus.c_address = 32'h2004;
    tick();
    n_checks++; if (bus.c_response !== RSP_DONE) begin n_errors++; $display("FAIL hit_done: got %0d want %0d", bus.c_response, RSP_DONE); end
    n_checks++; if (bus.c_load_data !== mem_word(32'h2004)) begin n_errors++; $display("FAIL hit_data: got %h want %h", bus.c_load_data, mem_word(32'h2004)); end
    n_checks++; if (bus.m_req !== 1'b0) begin n_errors++; $display("FAIL hit_noreq: got %b want 0", bus.m_req); end
    $display("txn EXECUTE 0x2004 (hit): resp=%0d data=%h", bus.c_response, bus.c_load_data);
    bus.c_cmd = CMD_NONE;
    tick();
    n_checks++; if (bus.c_response !== RSP_IDLE) begin n_errors++; $display("FAIL done_falls: got %0d want %0d", bus.c_response, RSP_IDLE); end
    n_checks++; if (bus.c_load_data !== mem_word(32'h2004)) begin n_errors++; $display("FAIL data_hold: got %h want %h", bus.c_load_data, mem_word(32'h2004)); end
    n_checks++; if (log_q.size() !== base) begin n_errors++; $display("FAIL hit_traffic: got %0d beats want 0", log_q.size() - base); end
  endtask

  task automatic test_missaligned();
    bus.c_cmd = CMD_EXECUTE;
    bus.c_address = 32'h2002;
    tick();
    n_checks++; if (bus.c_response !== RSP_MIS) begin n_errors++; $display("FAIL mis_resp: got %0d want %0d", bus.c_response, RSP_MIS); end
    n_checks++; if (bus.m_req !== 1'b0) begin n_errors++; $display("FAIL mis_noreq: got %b want 0", bus.m_req); end
    $display("txn EXECUTE 0x2002: resp=%0d", bus.c_response);
    bus.c_address = 32'h2000;
    tick();
    n_checks++; if (bus.c_response !== RSP_DONE) begin n_errors++; $display("FAIL mis_next_done: got %0d want %0d", bus.c_response, RSP_DONE); end
    n_checks++; if (bus.c_load_data !== mem_word(32'h2000)) begin n_errors++; $display("FAIL mis_next_data: got %h want %h", bus.c_load_data, mem_word(32'h2000)); end
    $display("txn EXECUTE 0x2000 (after misaligned): resp=%0d data=%h", bus.c_response, bus.c_load_data);
    bus.c_cmd = CMD_BAD;
    tick();
    n_checks++; if (bus.c_response !== RSP_AF) begin n_errors++; $display("FAIL badcmd_resp: got %0d want %0d", bus.c_response, RSP_AF); end
    $display("txn cmd 9: resp=%0d", bus.c_response);
    bus.c_cmd = CMD_NONE;
    tick();
    n_checks++; if (bus.c_response !== RSP_IDLE) begin n_errors++; $display("FAIL badcmd_falls: got %0d want %0d", bus.c_response, RSP_IDLE); end
  endtask

  task automatic test_bus_error();
    int k;
    int base;
    logic [31:0] a;
    err_addr = 32'h3004;
    base = log_q.size();
    bus.c_cmd = CMD_EXECUTE;
    bus.c_address = 32'h3000;
    tick();
    k = 1;
    while (k < 60 && bus.c_response === RSP_WAIT) begin tick(); k++; end
    n_checks++; if (k !== 6) begin n_errors++; $display("FAIL err_latency: got %0d want 6", k); end
    n_checks++; if (bus.c_response !== RSP_AF) begin n_errors++; $display("FAIL err_resp: got %0d want %0d", bus.c_response, RSP_AF); end
    n_checks++; if (bus.m_req !== 1'b0) begin n_errors++; $display("FAIL err_mreq: got %b want 0", bus.m_req); end
    n_checks++; if (log_q.size() - base !== 2) begin n_errors++; $display("FAIL err_beats: got %0d want 2", log_q.size() - base); end
    $display("txn EXECUTE 0x3000 (bus error): resp=%0d", bus.c_response);
    bus.c_cmd = CMD_NONE;
    err_addr = 32'hFFFF_FFFF;
    tick();
    n_checks++; if (bus.c_response !== RSP_IDLE) begin n_errors++; $display("FAIL err_one_cycle: got %0d want %0d", bus.c_response, RSP_IDLE); end
    base = log_q.size();
    bus.c_cmd = CMD_EXECUTE;
    tick();
    k = 1;
    while (k < 60 && bus.c_response === RSP_WAIT) begin tick(); k++; end
    a = (base < log_q.size()) ? log_q[base] : 32'hXXXX_XXXX;
    n_checks++; if (k !== 10) begin n_errors++; $display("FAIL refetch_latency: got %0d want 10", k); end
    n_checks++; if (a !== 32'h3000) begin n_errors++; $display("FAIL refetch_addr: got %h want 00003000", a); end
    n_checks++; if (bus.c_load_data !== mem_word(32'h3000)) begin n_errors++; $display("FAIL refetch_data: got %h want %h", bus.c_load_data, mem_word(32'h3000)); end
    $display("txn EXECUTE 0x3000 (refetch): resp=%0d data=%h", bus.c_response, bus.c_load_data);
    bus.c_cmd = CMD_NONE;
    tick();
  endtask

  task automatic test_flush();
    int k;
    int base;
    bus.c_cmd = CMD_FLUSH;
    tick();
    k = 1;
    n_checks++; if (bus.c_response !== RSP_WAIT) begin n_errors++; $display("FAIL flush_wait: got %0d want %0d", bus.c_response, RSP_WAIT); end
    while (k < 60 && bus.c_response === RSP_WAIT) begin tick(); k++; end
    n_checks++; if (k - 1 !== 16) begin n_errors++; $display("FAIL flush_len: got %0d wait cycles want 16", k - 1); end
    n_checks++; if (bus.c_response !== RSP_DONE) begin n_errors++; $display("FAIL flush_done: got %0d want %0d", bus.c_response, RSP_DONE); end
    $display("txn FLUSH_ALL: resp=%0d wait_cycles=%0d", bus.c_response, k - 1);
    // New command presented in the DONE cycle: the flushed line must miss.
    base = log_q.size();
    bus.c_cmd = CMD_EXECUTE;
    bus.c_address = 32'h2000;
    tick();
    n_checks++; if (bus.c_response !== RSP_WAIT) begin n_errors++; $display("FAIL flush_miss: got %0d want %0d", bus.c_response, RSP_WAIT); end
    k = 1;
    while (k < 60 && bus.c_response === RSP_WAIT) begin tick(); k++; end
    n_checks++; if (log_q.size() - base !== 4) begin n_errors++; $display("FAIL flush_refill: got %0d beats want 4", log_q.size() - base); end
    n_checks++; if (bus.c_load_data !== mem_word(32'h2000)) begin n_errors++; $display("FAIL flush_data: got %h want %h", bus.c_load_data, mem_word(32'h2000)); end
    $display("txn EXECUTE 0x2000 (after flush): resp=%0d data=%h", bus.c_response, bus.c_load_data);
    bus.c_cmd = CMD_NONE;
    tick();
  endtask

  task automatic test_reset_mid_refill();
    int k;
    int bad;
    int base;
    logic [31:0] a;
    mem_lat = 3;
    bus.c_cmd = CMD_EXECUTE;
    bus.c_address = 32'h4000;
    tick();
    tick();
    n_checks++; if (bus.m_req !== 1'b1) begin n_errors++; $display("FAIL mid_req: got %b want 1", bus.m_req); end
    rst_n = 1'b0;
    bus.c_cmd = CMD_NONE;
    tick();
    n_checks++; if (bus.m_req !== 1'b0) begin n_errors++; $display("FAIL mid_drop: got %b want 0", bus.m_req); end
    n_checks++; if (bus.c_reset_done !== 1'b0) begin n_errors++; $display("FAIL mid_done_low: got %b want 0", bus.c_reset_done); end
    n_checks++; if (bus.c_response !== RSP_IDLE) begin n_errors++; $display("FAIL mid_resp: got %0d want %0d", bus.c_response, RSP_IDLE); end
    // Release reset with a stray ack arriving during the sweep.
    base = log_q.size();
    rst_n = 1'b1;
    inj_req++;
    k = 0;
    bad = 0;
    while (k < 40 && bus.c_reset_done !== 1'b1) begin
      tick();
      k++;
      if (bus.c_response !== RSP_IDLE || bus.m_req !== 1'b0) bad++;
    end
    n_checks++; if (k !== 16) begin n_errors++; $display("FAIL mid_sweep_len: got %0d want 16", k); end
    n_checks++; if (bad !== 0) begin n_errors++; $display("FAIL mid_stale: %0d disturbed cycles want 0", bad); end
    $display("txn reset mid-refill: sweep %0d cycles", k);
    mem_lat = 2;
    bus.c_cmd = CMD_EXECUTE;
    bus.c_address = 32'h4000;
    tick();
    k = 1;
    while (k < 60 && bus.c_response === RSP_WAIT) begin tick(); k++; end
    a = (base < log_q.size()) ? log_q[base] : 32'hXXXX_XXXX;
    n_checks++; if (k !== 10 || bus.c_response !== RSP_DONE) begin n_errors++; $display("FAIL mid_refetch: latency %0d resp %0d want 10/%0d", k, bus.c_response, RSP_DONE); end
    n_checks++; if (a !== 32'h4000 || log_q.size() - base !== 4) begin n_errors++; $display("FAIL mid_refetch_addr: first %h beats %0d want 00004000/4", a, log_q.size() - base); end
    n_checks++; if (bus.c_load_data !== mem_word(32'h4000)) begin n_errors++; $display("FAIL mid_refetch_data: got %h want %h", bus.c_load_data, mem_word(32'h4000)); end
    $display("txn EXECUTE 0x4000 (after reset): resp=%0d data=%h", bus.c_response, bus.c_load_data);
    bus.c_cmd = CMD_NONE;
    tick();
  endtask

  initial begin
    bus.c_cmd = CMD_NONE;
    bus.c_address = '0;
    test_reset();
    test_cold_miss();
    test_missaligned();
    test_bus_error();
    test_flush();
    test_reset_mid_refill();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
